// File: rtl/soc_simple_clken_gen.sv
// Programmable clock-enable generator: per-channel divide/phase strobes gated by a settle/lock FSM.
// Optional 50%-duty level outputs when SOC_CLKEN_LEVEL_OUT_EN is defined.
module soc_simple_clken_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_chan,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic                  locked
`ifdef SOC_CLKEN_LEVEL_OUT_EN
  ,
  output logic [NUM_CLOCKS-1:0] clklvl
`endif
);

  // state    | meaning
  // RST_HOLD | rst asserted; no requests accepted
  // SETTLE   | channels running, waiting LOCK_CYCLES before locked
  // LOCKED   | locked asserted, strobes enabled
  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    SETTLE   = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [15:0]            settle_q, settle_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   locked_q, locked_d;
  logic [NUM_CLOCKS-1:0]  clken_q, clken_d;
  logic [DIV_WIDTH-1:0]   div_q   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   div_d   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   phase_q [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   phase_d [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   cnt_q   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   cnt_d   [NUM_CLOCKS];
`ifdef SOC_CLKEN_LEVEL_OUT_EN
  logic [NUM_CLOCKS-1:0]  clklvl_q, clklvl_d;
  logic [DIV_WIDTH-1:0]   half_div;
`endif

  logic accept;
  logic chan_bad;
  logic phase_bad;
  logic cfg_ok;
  logic running;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    cfg_err_d = 1'b0;
    for (int n = 0; n < NUM_CLOCKS; n++) begin
      div_d[n]   = div_q[n];
      phase_d[n] = phase_q[n];
      cnt_d[n]   = cnt_q[n];
    end

    cfg_ready = (state_q != RST_HOLD);
    accept    = cfg_valid && cfg_ready;
    chan_bad  = (32'(cfg_chan) >= 32'(NUM_CLOCKS));
    phase_bad = (cfg_div != '0) && (cfg_phase >= cfg_div);
    cfg_ok    = !chan_bad && !phase_bad;
    running   = (state_q == SETTLE) || (state_q == LOCKED);

    case (state_q)
      RST_HOLD: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (settle_q >= LOCK_LAST) begin
          state_d  = LOCKED;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      LOCKED: begin
        settle_d = '0;
      end
      default: begin
        state_d  = RST_HOLD;
        settle_d = '0;
      end
    endcase

    if (running) begin
      for (int n = 0; n < NUM_CLOCKS; n++) begin
        if ((div_q[n] <= DIV_WIDTH'(1)) || (cnt_q[n] >= div_q[n] - DIV_WIDTH'(1)))
          cnt_d[n] = '0;
        else
          cnt_d[n] = cnt_q[n] + DIV_WIDTH'(1);
      end
    end

    if (accept) begin
      if (cfg_ok) begin
        state_d  = SETTLE;
        settle_d = '0;
        for (int n = 0; n < NUM_CLOCKS; n++) begin
          if (cfg_chan == 3'(n)) begin
            div_d[n]   = cfg_div;
            phase_d[n] = cfg_phase;
            cnt_d[n]   = '0;
          end
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Realign every channel to count 0 on the lock edge so the first strobe
    // coincides with the first locked cycle.
    if ((state_q == SETTLE) && (state_d == LOCKED)) begin
      for (int n = 0; n < NUM_CLOCKS; n++) cnt_d[n] = '0;
    end

    locked_d = (state_d == LOCKED);
    for (int n = 0; n < NUM_CLOCKS; n++) begin
      clken_d[n] = locked_d && (div_d[n] != '0) && (cnt_d[n] == phase_d[n]);
    end
  end

`ifdef SOC_CLKEN_LEVEL_OUT_EN
  always_comb begin
    clklvl_d = '0;
    half_div = '0;
    for (int n = 0; n < NUM_CLOCKS; n++) begin
      half_div    = (div_d[n] >> 1) + DIV_WIDTH'(div_d[n][0]);
      clklvl_d[n] = locked_d && (div_d[n] != '0) && (cnt_d[n] < half_div);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) clklvl_q <= '0;
    else     clklvl_q <= clklvl_d;
  end

  assign clklvl = clklvl_q;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      settle_q  <= '0;
      cfg_err_q <= 1'b0;
      locked_q  <= 1'b0;
      clken_q   <= '0;
      for (int n = 0; n < NUM_CLOCKS; n++) begin
        div_q[n]   <= DIV_WIDTH'(DEFAULT_DIV);
        phase_q[n] <= '0;
        cnt_q[n]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cfg_err_q <= cfg_err_d;
      locked_q  <= locked_d;
      clken_q   <= clken_d;
      for (int n = 0; n < NUM_CLOCKS; n++) begin
        div_q[n]   <= div_d[n];
        phase_q[n] <= phase_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  assign cfg_err = cfg_err_q;
  assign locked  = locked_q;
  assign clken   = clken_q;

endmodule

// File: doc/soc_simple_clken_gen.md
SOC_SIMPLE_CLKEN_GEN -- requirements
Module: soc_simple_clken_gen

Interface
REQ-001 Parameter NUM_CLOCKS, default 2: number of clock-enable channels, legal 1..8.
REQ-002 Parameter DIV_WIDTH, default 8: width of divide and phase values.
REQ-003 Parameter DEFAULT_DIV, default 3: divide ratio loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16: settle-counter length before locked asserts, legal 1..65535.
REQ-005 Clocking is decided: one clock, refclk; rst is synchronous and active-high.
REQ-006 refclk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 cfg_valid  input  1  configuration request.
REQ-009 cfg_ready  output  1  block can accept a configuration this cycle.
REQ-010 cfg_chan  input  3  target channel index.
REQ-011 cfg_div  input  DIV_WIDTH  new divide ratio; 0 disables the channel.
REQ-012 cfg_phase  input  DIV_WIDTH  counter value at which the channel pulses.
REQ-013 cfg_err  output  1  one-cycle pulse: the accepted request was invalid.
REQ-014 clken  output  NUM_CLOCKS  per-channel one-cycle enable strobes.
REQ-015 locked  output  1  all channels are running with stable configuration.

Function
REQ-016 State machine states: RST_HOLD, SETTLE, LOCKED.
- RST_HOLD: entered only while rst is high.
- RST_HOLD -> SETTLE: on the first cycle with rst low.
- SETTLE -> LOCKED: after LOCK_CYCLES cycles in SETTLE.
- LOCKED -> SETTLE: on an accepted valid request.
REQ-017 cfg_ready is 1 in SETTLE and LOCKED and 0 in RST_HOLD.
REQ-018 A request is accepted on a cycle with cfg_valid && cfg_ready.
REQ-019 Invalid request: cfg_chan >= NUM_CLOCKS, or cfg_div != 0 with cfg_phase >= cfg_div.
- Effect: no channel changes, the state is unchanged, and cfg_err pulses the following cycle.
REQ-020 Valid request effects, on the next edge:
- the channel's div and phase registers load;
- the channel's counter clears to 0;
- the settle counter clears;
- the state becomes SETTLE;
- locked drops to 0 on that same edge.
REQ-021 A valid request accepted during SETTLE restarts the settle count from 0.
REQ-022 Each channel counter runs in SETTLE and LOCKED.
- Count sequence: 0, 1, ..., div-1, then wraps to 0.
- div=1: the counter holds at 0.
- div=0: the counter holds at 0.
REQ-023 clken[n] = locked && div[n] != 0 && counter[n] == phase[n], registered.
- The pulse is high for exactly one cycle per div[n] cycles.
- div=1 gives continuous 1.
REQ-024 locked is registered and is 1 only in LOCKED.
- The first clken pulse may appear on the first cycle that locked is 1.
REQ-025 The divide arithmetic is unsigned DIV_WIDTH.
- The counter compare uses full width.
- There is no overflow, because count < div <= 2^DIV_WIDTH-1.
REQ-026 Simultaneous rst and cfg_valid: rst wins and the request is dropped with no cfg_err.

Reset
REQ-027 On an rst edge:
- state becomes RST_HOLD;
- all counters are 0;
- div = DEFAULT_DIV and phase = 0 for every channel;
- the settle counter is 0;
- clken, locked, cfg_ready and cfg_err are 0.
REQ-028 rst asserted mid-operation (including mid-SETTLE) discards all runtime configuration on the next edge.

Configuration
REQ-029 Macro SOC_CLKEN_LEVEL_OUT_EN adds output clklvl[NUM_CLOCKS], registered.
- clklvl[n] = locked && div[n] != 0 && counter[n] < ceil(div[n]/2).
- Result: about 50% duty, high at counter 0.
REQ-030 With the macro defined, div=1 gives clklvl constantly 1 while locked.
REQ-031 Without the macro, the clklvl port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then rst low, with defaults (NUM_CLOCKS=2, DEFAULT_DIV=3, LOCK_CYCLES=16).
- locked rises 16 cycles after the SETTLE entry.
- clken[0] and clken[1] then pulse every 3 cycles, starting with the locked cycle.
REQ-033 Config while LOCKED: chan=1, div=5, phase=2.
- locked falls on the next edge.
- locked re-rises 16 cycles later.
- clken[1] then pulses at counter 2 every 5 cycles; clken[0] keeps period 3.
REQ-034 Invalid configs:
- chan=5 -> cfg_err pulse, locked stays 1, clken unchanged.
- div=4, phase=4 -> cfg_err pulse, no change.
REQ-035 Boundary configs:
- div=0 on chan 0 -> after relock, clken[0] constant 0.
- div=1 -> clken[0] constant 1 while locked.
REQ-036 rst asserted 5 cycles into SETTLE, together with cfg_valid -> no cfg_err; outputs 0; div returns to 3.
REQ-037 With SOC_CLKEN_LEVEL_OUT_EN and div=4 -> clklvl pattern 1,1,0,0 repeating while locked.
